// File: rtl/pb_hub_pkg.sv
// Shared constants for the PicoBlaze UART hub: register offsets, echo state encoding, channel limit.
package pb_hub_pkg;

    localparam int MAX_CH = 8;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ECHO_IDLE   = 2'd0,
        ECHO_FWD    = 2'd1,
        ECHO_SETTLE = 2'd2
    } echo_state_t;

endpackage

// File: rtl/pb_hub_channel.sv
// One UART channel of the hub: register slice, RX pop counter and, with HUB_ECHO_EN, the echo engine.
//   state       | meaning
//   ECHO_IDLE   | waiting for echo_en, an RX byte and TX room
//   ECHO_FWD    | byte forwarded: TX write and RX pop pulsed this cycle
//   ECHO_SETTLE | one cycle for the UART flags to catch up
module pb_hub_channel
    import pb_hub_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic [1:0] off,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_full,
    input  logic [7:0] rx_data,
    input  logic       rx_present,
    output logic       rx_ack
);

    logic       cpu_data_wr;
    logic       cpu_data_rd;
    logic       ctrl_wr;
    logic       count_clr;
    logic       cpu_pop;
    logic       echo_en;
    logic       echo_busy;
    logic [7:0] rx_count;

    assign cpu_data_wr = sel & write_strobe & (off == OFF_DATA);
    assign cpu_data_rd = sel & read_strobe  & (off == OFF_DATA);
    assign ctrl_wr     = sel & write_strobe & (off == OFF_CTRL);
    assign count_clr   = ctrl_wr & wr_data[1];

`ifdef HUB_ECHO_EN
    echo_state_t state;
    logic        pend_v;
    logic [7:0]  pend_data;
    logic        go;

    assign cpu_pop   = cpu_data_rd & ~echo_en;
    assign go        = (state == ECHO_IDLE) & echo_en & rx_present & ~tx_full
                       & ~cpu_data_wr & ~pend_v;
    assign echo_busy = (state != ECHO_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ECHO_IDLE;
            echo_en   <= 1'b0;
            pend_v    <= 1'b0;
            pend_data <= 8'h00;
            tx_write  <= 1'b0;
            tx_data   <= 8'h00;
            rx_ack    <= 1'b0;
            rx_count  <= 8'h00;
        end else begin
            tx_write <= 1'b0;
            rx_ack   <= cpu_pop;
            if (ctrl_wr)
                echo_en <= wr_data[0];

            case (state)
                ECHO_IDLE: begin
                    if (go) begin
                        state    <= ECHO_FWD;
                        tx_write <= 1'b1;
                        tx_data  <= rx_data;
                        rx_ack   <= 1'b1;
                    end
                end
                ECHO_FWD: state <= ECHO_SETTLE;
                default:  state <= ECHO_IDLE;
            endcase

            // A CPU write landing on FWD is parked and goes out on the next free slot
            if (pend_v && state != ECHO_FWD) begin
                tx_write  <= 1'b1;
                tx_data   <= pend_data;
                pend_v    <= cpu_data_wr;
                pend_data <= wr_data;
            end else if (cpu_data_wr) begin
                if (state == ECHO_FWD) begin
                    pend_v    <= 1'b1;
                    pend_data <= wr_data;
                end else begin
                    tx_write <= 1'b1;
                    tx_data  <= wr_data;
                end
            end

            if (count_clr)
                rx_count <= 8'h00;
            else if (go | cpu_pop)
                rx_count <= rx_count + 8'd1;
        end
    end
`else
    assign cpu_pop   = cpu_data_rd;
    assign echo_en   = 1'b0;
    assign echo_busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_write <= 1'b0;
            tx_data  <= 8'h00;
            rx_ack   <= 1'b0;
            rx_count <= 8'h00;
        end else begin
            tx_write <= cpu_data_wr;
            if (cpu_data_wr)
                tx_data <= wr_data;
            rx_ack <= cpu_pop;
            if (count_clr)
                rx_count <= 8'h00;
            else if (cpu_pop)
                rx_count <= rx_count + 8'd1;
        end
    end
`endif

    always_comb begin
        rd_data = 8'h00;
        case (off)
            OFF_DATA:   rd_data = rx_data;
            OFF_STATUS: rd_data = {5'b0, echo_busy, tx_full, rx_present};
            OFF_CTRL:   rd_data = {7'b0, echo_en};
            default:    rd_data = rx_count;
        endcase
    end

endmodule

// File: rtl/pb_uart_hub.sv
// PicoBlaze port-mapped hub for NUM_CH UART channels: address decode and registered read mux.
// Define HUB_ECHO_EN to build the per-channel hardware echo engine.
module pb_uart_hub
    import pb_hub_pkg::*;
#(
    parameter int         NUM_CH = 2,
    parameter logic [7:0] BASE   = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    input  logic [7:0]            out_port,
    output logic [7:0]            in_port,
    output logic [8*NUM_CH-1:0]   uart_tx_data,
    output logic [NUM_CH-1:0]     uart_write,
    input  logic [NUM_CH-1:0]     uart_tx_full,
    input  logic [8*NUM_CH-1:0]   uart_rx_data,
    input  logic [NUM_CH-1:0]     uart_rx_present,
    output logic [NUM_CH-1:0]     uart_read_ack
);

    localparam logic [8:0] SPAN = 9'(4 * NUM_CH);

    logic [7:0]        rel;
    logic              hit;
    logic [2:0]        ch;
    logic [NUM_CH-1:0] sel;
    logic [7:0]        rd_ch [NUM_CH];
    logic [7:0]        rd_mux;

    assign rel = port_id - BASE;
    assign hit = (port_id >= BASE) && ({1'b0, rel} < SPAN);
    assign ch  = rel[4:2];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign sel[c] = hit && (ch == 3'(c));

        pb_hub_channel u_ch (
            .clk          (clk),
            .reset        (reset),
            .sel          (sel[c]),
            .off          (rel[1:0]),
            .read_strobe  (read_strobe),
            .write_strobe (write_strobe),
            .wr_data      (out_port),
            .rd_data      (rd_ch[c]),
            .tx_data      (uart_tx_data[8*c +: 8]),
            .tx_write     (uart_write[c]),
            .tx_full      (uart_tx_full[c]),
            .rx_data      (uart_rx_data[8*c +: 8]),
            .rx_present   (uart_rx_present[c]),
            .rx_ack       (uart_read_ack[c])
        );
    end

    // Misses leave every sel low, so they read back as zero
    always_comb begin
        rd_mux = 8'h00;
        for (int c = 0; c < NUM_CH; c++)
            if (sel[c])
                rd_mux = rd_ch[c];
    end

    always_ff @(posedge clk) begin
        if (reset)
            in_port <= 8'h00;
        else
            in_port <= rd_mux;
    end

endmodule

// File: tb/tb_pb_uart_hub.sv
// Randomised bench for pb_uart_hub; echo scenarios run only when HUB_ECHO_EN is defined.
module tb_pb_uart_hub;

    localparam int         NCH  = 2;
    localparam logic [7:0] BASE = 8'h10;
`ifdef HUB_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           port_id;
    logic                 read_strobe;
    logic                 write_strobe;
    logic [7:0]           out_port;
    logic [7:0]           in_port;
    logic [8*NCH-1:0]     uart_tx_data;
    logic [NCH-1:0]       uart_write;
    logic [NCH-1:0]       uart_tx_full;
    logic [8*NCH-1:0]     uart_rx_data;
    logic [NCH-1:0]       uart_rx_present;
    logic [NCH-1:0]       uart_read_ack;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_count [NCH];
    logic [7:0] m_tx    [NCH];

    always #5 clk = ~clk;

    pb_uart_hub #(.NUM_CH(NCH), .BASE(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .port_id         (port_id),
        .read_strobe     (read_strobe),
        .write_strobe    (write_strobe),
        .out_port        (out_port),
        .in_port         (in_port),
        .uart_tx_data    (uart_tx_data),
        .uart_write      (uart_write),
        .uart_tx_full    (uart_tx_full),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_present (uart_rx_present),
        .uart_read_ack   (uart_read_ack)
    );

    function automatic logic [8*NCH-1:0] m_txvec();
        logic [8*NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[8*c +: 8] = m_tx[c];
        return v;
    endfunction

    function automatic logic [7:0] addr(input int c, input int off);
        return BASE + 8'(4 * c + off);
    endfunction

    // One bus cycle with strobes, then an idle cycle; returns what the DUT shows after it
    task automatic access(input logic [7:0] pid, input logic rd, input logic wr, input logic [7:0] d,
                          output logic [7:0] rdv, output logic [NCH-1:0] wrv, output logic [NCH-1:0] ackv);
        @(posedge clk); #1;
        port_id = pid; read_strobe = rd; write_strobe = wr; out_port = d;
        @(posedge clk); #1;
        read_strobe = 1'b0; write_strobe = 1'b0;
        rdv = in_port; wrv = uart_write; ackv = uart_read_ack;
    endtask

    task automatic test_reset();
        logic [7:0] r; logic [NCH-1:0] w, a;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (in_port !== 8'h00) begin miscompares++; $display("FAIL reset_in_port: got %h expected 00", in_port); end
        vectors++; if ({uart_write, uart_read_ack} !== '0) begin miscompares++; $display("FAIL reset_pulses: got %b expected 0", {uart_write, uart_read_ack}); end
        vectors++; if (uart_tx_data !== '0) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 0", uart_tx_data); end
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_count[c] = 8'h00; m_tx[c] = 8'h00;
            access(addr(c, 3), 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL reset_count ch%0d: got %h expected 00", c, r); end
            access(addr(c, 2), 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl ch%0d: got %h expected 00", c, r); end
        end
    endtask

    task automatic test_status();
        logic [7:0] r, exp; logic [NCH-1:0] w, a;
        int c;
        uart_rx_present = 2'b01; uart_tx_full = 2'b00;
        access(addr(0, 1), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("FAIL status_first: got %h expected 01", r); end
        vectors++; if ({w, a} !== '0) begin miscompares++; $display("FAIL status_pulses: got %b expected 0", {w, a}); end
        for (int i = 0; i < 8; i++) begin
            uart_rx_present = NCH'($urandom);
            uart_tx_full    = NCH'($urandom);
            c = int'($urandom_range(0, NCH - 1));
            exp = {6'b0, uart_tx_full[c], uart_rx_present[c]};
            access(addr(c, 1), 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== exp || a !== '0) begin miscompares++; $display("FAIL status ch%0d: got %h ack %b expected %h ack 0", c, r, a, exp); end
        end
    endtask

    task automatic test_write();
        logic [7:0] r, d; logic [NCH-1:0] w, a;
        int c;
        for (int i = 0; i < 10; i++) begin
            c = int'($urandom_range(0, NCH - 1));
            d = 8'($urandom);
            m_tx[c] = d;
            access(addr(c, 0), 1'b0, 1'b1, d, r, w, a);
            vectors++; if (w !== NCH'(1 << c) || uart_tx_data !== m_txvec()) begin
                miscompares++; $display("FAIL write ch%0d: got wr %b data %h expected wr %b data %h", c, w, uart_tx_data, NCH'(1 << c), m_txvec());
            end
            @(posedge clk); #1;
            vectors++; if (uart_write !== '0) begin miscompares++; $display("FAIL write_width ch%0d: got %b expected 0", c, uart_write); end
        end
    endtask

    task automatic test_read_pop();
        logic [7:0] r; logic [NCH-1:0] w, a;
        int c;
        uart_rx_present = '1;
        for (int i = 0; i < 10; i++) begin
            uart_rx_data = (8*NCH)'({$urandom, $urandom});
            c = int'($urandom_range(0, NCH - 1));
            m_count[c] = m_count[c] + 8'd1;
            access(addr(c, 0), 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== uart_rx_data[8*c +: 8] || a !== NCH'(1 << c)) begin
                miscompares++; $display("FAIL pop ch%0d: got %h ack %b expected %h ack %b", c, r, a, uart_rx_data[8*c +: 8], NCH'(1 << c));
            end
        end
        for (int k = 0; k < NCH; k++) begin
            access(addr(k, 3), 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== m_count[k]) begin miscompares++; $display("FAIL pop_count ch%0d: got %h expected %h", k, r, m_count[k]); end
        end
    endtask

    task automatic test_miss();
        logic [7:0] r, p, d; logic [NCH-1:0] w, a;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) p = 8'h05;
            else begin
                p = 8'($urandom);
                while (p >= BASE && p < BASE + 8'(4 * NCH)) p = 8'($urandom);
            end
            d = 8'($urandom);
            access(p, 1'b1, 1'b0, 8'h00, r, w, a);
            vectors++; if (r !== 8'h00 || a !== '0) begin miscompares++; $display("FAIL miss_read %h: got %h ack %b expected 00 ack 0", p, r, a); end
            access(p, 1'b0, 1'b1, d, r, w, a);
            vectors++; if (w !== '0 || uart_tx_data !== m_txvec()) begin
                miscompares++; $display("FAIL miss_write %h: got wr %b data %h expected wr 0 data %h", p, w, uart_tx_data, m_txvec());
            end
        end
    endtask

    task automatic test_ctrl();
        logic [7:0] r; logic [NCH-1:0] w, a, exp_ack;
        uart_rx_present[1] = 1'b0;
        access(addr(1, 2), 1'b0, 1'b1, 8'h01, r, w, a);
        access(addr(1, 2), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== {7'b0, ECHO}) begin miscompares++; $display("FAIL ctrl_read: got %h expected %h", r, {7'b0, ECHO}); end
        exp_ack = ECHO ? 2'b00 : 2'b10;
        if (!ECHO) m_count[1] = m_count[1] + 8'd1;
        access(addr(1, 0), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (a !== exp_ack) begin miscompares++; $display("FAIL ctrl_pop_gate: got %b expected %b", a, exp_ack); end
        access(addr(1, 2), 1'b0, 1'b1, 8'h00, r, w, a);
        access(addr(1, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[1]) begin miscompares++; $display("FAIL ctrl_count: got %h expected %h", r, m_count[1]); end
    endtask

    task automatic test_wrap();
        logic [7:0] r; logic [NCH-1:0] w, a;
        int bad = 0;
        access(addr(1, 2), 1'b0, 1'b1, 8'h02, r, w, a);
        m_count[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            access(addr(1, 0), 1'b1, 1'b0, 8'h00, r, w, a);
            m_count[1] = m_count[1] + 8'd1;
            if (a !== 2'b10) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wrap_acks: got %0d bad pops expected 0", bad); end
        access(addr(1, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[1]) begin miscompares++; $display("FAIL wrap_count: got %h expected %h", r, m_count[1]); end
        for (int i = 0; i < 3; i++) begin
            access(addr(1, 0), 1'b1, 1'b0, 8'h00, r, w, a);
            m_count[1] = m_count[1] + 8'd1;
        end
        access(addr(1, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[1]) begin miscompares++; $display("FAIL count_3: got %h expected %h", r, m_count[1]); end
        access(addr(1, 2), 1'b0, 1'b1, 8'h02, r, w, a);
        m_count[1] = 8'h00;
        access(addr(1, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[1]) begin miscompares++; $display("FAIL count_clear: got %h expected %h", r, m_count[1]); end
        access(addr(1, 2), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL clear_selfclr: got %h expected 00", r); end
    endtask

`ifdef HUB_ECHO_EN
    // Waits (bounded) for the ch0 echo write; returns 1 when seen
    task automatic wait_echo(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (uart_write[0]) seen = 1'b1;
        end
    endtask

    task automatic test_echo();
        logic [7:0] r; logic [NCH-1:0] w, a;
        logic [7:0] q[$];
        int cyc = 0, last = -10, done = 0;
        uart_rx_present = '0; uart_tx_full = '0;
        access(addr(0, 2), 1'b0, 1'b1, 8'h01, r, w, a);
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        uart_rx_data[7:0] = q[0]; uart_rx_present[0] = 1'b1;
        while (cyc < 40 && done < 3) begin
            @(posedge clk); #1;
            cyc++;
            if (uart_write[0]) begin
                vectors++; if (uart_read_ack[0] !== 1'b1 || uart_tx_data[7:0] !== q[0] || cyc - last < 3 || uart_write[1] !== 1'b0) begin
                    miscompares++; $display("FAIL echo_byte %0d: got ack %b data %h gap %0d expected ack 1 data %h gap>=3", done, uart_read_ack[0], uart_tx_data[7:0], cyc - last, q[0]);
                end
                last = cyc; m_tx[0] = q.pop_front(); done++;
                m_count[0] = m_count[0] + 8'd1;
                if (q.size() == 0) uart_rx_present[0] = 1'b0;
                else uart_rx_data[7:0] = q[0];
            end
        end
        vectors++; if (done != 3) begin miscompares++; $display("FAIL echo_total: got %0d expected 3", done); end
        access(addr(0, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[0]) begin miscompares++; $display("FAIL echo_count: got %h expected %h", r, m_count[0]); end
    endtask

    task automatic test_pending();
        logic [7:0] r, b; logic [NCH-1:0] w, a;
        bit seen; int wrote = 0;
        b = 8'($urandom);
        @(posedge clk); #1;
        uart_rx_data[7:0] = b; uart_rx_present[0] = 1'b1;
        wait_echo(10, seen);
        vectors++; if (!seen || uart_tx_data[7:0] !== b) begin miscompares++; $display("FAIL pend_echo: got seen %b data %h expected seen 1 data %h", seen, uart_tx_data[7:0], b); end
        m_count[0] = m_count[0] + 8'd1;
        uart_rx_present[0] = 1'b0;
        port_id = addr(0, 0); out_port = 8'h7E; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0;
        vectors++; if (uart_write[0] !== 1'b0) begin miscompares++; $display("FAIL pend_hold: got %b expected 0", uart_write[0]); end
        @(posedge clk); #1;
        vectors++; if (uart_write[0] !== 1'b1 || uart_tx_data[7:0] !== 8'h7E) begin
            miscompares++; $display("FAIL pend_issue: got wr %b data %h expected wr 1 data 7e", uart_write[0], uart_tx_data[7:0]);
        end
        m_tx[0] = 8'h7E;
        uart_tx_full[0] = 1'b1; b = 8'($urandom);
        uart_rx_data[7:0] = b; uart_rx_present[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (uart_write[0]) wrote++;
        end
        vectors++; if (wrote != 0) begin miscompares++; $display("FAIL stall_write: got %0d writes expected 0", wrote); end
        access(addr(0, 1), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== 8'h03) begin miscompares++; $display("FAIL stall_status: got %h expected 03", r); end
        uart_tx_full[0] = 1'b0;
        wait_echo(10, seen);
        vectors++; if (!seen || uart_tx_data[7:0] !== b) begin miscompares++; $display("FAIL stall_release: got seen %b data %h expected seen 1 data %h", seen, uart_tx_data[7:0], b); end
        uart_rx_present[0] = 1'b0; m_tx[0] = b;
        m_count[0] = m_count[0] + 8'd1;
        access(addr(0, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[0]) begin miscompares++; $display("FAIL pend_count: got %h expected %h", r, m_count[0]); end
    endtask

    task automatic test_echo_clear();
        logic [7:0] r, b; logic [NCH-1:0] w, a;
        repeat (3) @(posedge clk);
        #1;
        b = 8'($urandom);
        uart_rx_data[7:0] = b; uart_rx_present[0] = 1'b1;
        port_id = addr(0, 2); out_port = 8'h03; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0; uart_rx_present[0] = 1'b0;
        vectors++; if (uart_write[0] !== 1'b1 || uart_read_ack[0] !== 1'b1) begin
            miscompares++; $display("FAIL clr_pop_echo: got wr %b ack %b expected 1 1", uart_write[0], uart_read_ack[0]);
        end
        m_tx[0] = b; m_count[0] = 8'h00;
        access(addr(0, 3), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== m_count[0]) begin miscompares++; $display("FAIL clr_pop_count: got %h expected %h", r, m_count[0]); end
    endtask

    task automatic test_echo_reset();
        logic [7:0] r; logic [NCH-1:0] w, a;
        bit seen; int pulses = 0;
        @(posedge clk); #1;
        uart_rx_data[7:0] = 8'($urandom); uart_rx_present[0] = 1'b1;
        wait_echo(10, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL rst_echo_start: got 0 expected 1"); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin m_count[c] = 8'h00; m_tx[c] = 8'h00; end
        for (int i = 0; i < 5; i++) begin
            if (uart_write !== '0 || uart_read_ack !== '0) pulses++;
            @(posedge clk); #1;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rst_abort: got %0d pulse cycles expected 0", pulses); end
        vectors++; if (uart_tx_data !== m_txvec()) begin miscompares++; $display("FAIL rst_tx_data: got %h expected %h", uart_tx_data, m_txvec()); end
        uart_rx_present[0] = 1'b0;
        access(addr(0, 2), 1'b1, 1'b0, 8'h00, r, w, a);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL rst_ctrl: got %h expected 00", r); end
    endtask
`endif

    initial begin
        reset = 1'b1; port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0; out_port = 8'h00;
        uart_tx_full = '0; uart_rx_data = '0; uart_rx_present = '0;
        test_reset();
        test_status();
        test_write();
        test_read_pop();
        test_miss();
        test_ctrl();
        test_wrap();
`ifdef HUB_ECHO_EN
        test_echo();
        test_pending();
        test_echo_clear();
        test_echo_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
